// File: rtl/oneshot_pkg.sv
// Shared state encoding and trigger-edge selectors
// for the multi-channel one-shot.
package oneshot_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_LOCK  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/oneshot_channel.sv
// One channel: input synchroniser, edge detect,
// pulse/hold/lockout FSM and its down-counter.
module oneshot_channel
  import oneshot_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int EDGE        = 0,
  parameter int RETRIGGER   = 0,
  parameter int HOLD        = 1,
  parameter int LOCKOUT     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  input  logic [LEN_W-1:0] pulse_len,
  output logic             dout,
  output logic             fire,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LOCK_M1 =
    (LOCKOUT > 0) ? LEN_W'(LOCKOUT - 1) : '0;
  localparam logic [1:0] END_ST =
    (LOCKOUT > 0) ? S_LOCK : S_IDLE;

  logic [SYNC_STAGES:0] r_sync;
  logic [1:0]           r_state;
  logic [LEN_W-1:0]     r_cnt;
  logic                 r_dout;
  logic                 r_fire;

  logic             w_lvl;
  logic             w_prev;
  logic             w_trig;
  logic             w_act;
  logic [LEN_W-1:0] w_len_m1;

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign w_prev = r_sync[SYNC_STAGES];

  always_comb begin
    w_trig = 1'b0;
    unique case (1'b1)
      (EDGE == EDGE_FALL): w_trig = ~w_lvl & w_prev;
      (EDGE == EDGE_BOTH): w_trig = w_lvl ^ w_prev;
      default:             w_trig = w_lvl & ~w_prev;
    endcase
  end

  assign w_act = (EDGE == EDGE_FALL) ? ~w_lvl : w_lvl;

  // zero length is stretched to a single cycle
  assign w_len_m1 = (pulse_len == '0) ? '0
                  : pulse_len - LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_fire  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-1:0], din};
      r_fire <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_dout  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_trig) begin
              r_state <= S_PULSE;
              r_cnt   <= w_len_m1;
              r_dout  <= 1'b1;
              r_fire  <= 1'b1;
            end
          end
          S_PULSE: begin
            if ((RETRIGGER != 0) && w_trig) begin
              r_cnt  <= w_len_m1;
              r_fire <= 1'b1;
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - LEN_W'(1);
            end else if ((HOLD != 0) && w_act) begin
              r_state <= S_HOLD;
            end else begin
              r_dout  <= 1'b0;
              r_state <= END_ST;
              r_cnt   <= LOCK_M1;
            end
          end
          S_HOLD: begin
            if (!w_act) begin
              r_dout  <= 1'b0;
              r_state <= END_ST;
              r_cnt   <= LOCK_M1;
            end
          end
          S_LOCK: begin
            if (r_cnt == '0) r_state <= S_IDLE;
            else r_cnt <= r_cnt - LEN_W'(1);
          end
        endcase
      end
    end
  end

  assign dout = r_dout;
  assign fire = r_fire;
  assign busy = (r_state != S_IDLE);

endmodule

// File: rtl/oneshot_multi.sv
// CHANNELS independent one-shots; this level only
// slices pulse_len and replicates the channel.
module oneshot_multi
  import oneshot_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int LEN_W       = 16,
  parameter int EDGE        = EDGE_RISE,
  parameter int RETRIGGER   = 0,
  parameter int HOLD        = 1,
  parameter int LOCKOUT     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       din,
  input  logic [CHANNELS*LEN_W-1:0] pulse_len,
  output logic [CHANNELS-1:0]       dout,
  output logic [CHANNELS-1:0]       fire,
  output logic [CHANNELS-1:0]       busy
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    oneshot_channel #(
      .LEN_W      (LEN_W),
      .EDGE       (EDGE),
      .RETRIGGER  (RETRIGGER),
      .HOLD       (HOLD),
      .LOCKOUT    (LOCKOUT),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable[i]),
      .din      (din[i]),
      .pulse_len(pulse_len[i*LEN_W +: LEN_W]),
      .dout     (dout[i]),
      .fire     (fire[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_oneshot_multi.sv
// Randomised bench for oneshot_multi: three parameter
// sets share stimulus, each checked against a cycle model.
module tb_oneshot_multi;

  localparam int NC = 4;
  localparam int LW = 16;
  localparam int ND = 3;

  localparam int P_EDGE [ND] = '{0, 2, 1};
  localparam int P_RT   [ND] = '{0, 1, 0};
  localparam int P_HD   [ND] = '{1, 0, 1};
  localparam int P_LK   [ND] = '{0, 8, 3};
  localparam int P_SS   [ND] = '{2, 2, 3};

  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0]    en;
  logic [NC-1:0]    din;
  logic [NC*LW-1:0] pl;

  logic [NC-1:0] o_d [ND];
  logic [NC-1:0] o_f [ND];
  logic [NC-1:0] o_b [ND];

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    oneshot_multi #(
      .CHANNELS   (NC),
      .LEN_W      (LW),
      .EDGE       (P_EDGE[d]),
      .RETRIGGER  (P_RT[d]),
      .HOLD       (P_HD[d]),
      .LOCKOUT    (P_LK[d]),
      .SYNC_STAGES(P_SS[d])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (en),
      .din      (din),
      .pulse_len(pl),
      .dout     (o_d[d]),
      .fire     (o_f[d]),
      .busy     (o_b[d])
    );
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference: samp history, remaining-high and
  // remaining-dead counts per channel
  bit hist [NC][4];
  int hi   [ND][NC];
  int lk   [ND][NC];
  bit hold [ND][NC];
  bit md   [ND][NC];
  bit mf   [ND][NC];

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 4; k++) hist[c][k] = 1'b0;
      for (int d = 0; d < ND; d++) begin
        hi[d][c] = 0; lk[d][c] = 0;
        hold[d][c] = 0; md[d][c] = 0; mf[d][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        bit lvl, prv, t, act;
        int len;
        lvl = hist[c][P_SS[d]-1];
        prv = hist[c][P_SS[d]];
        if (P_EDGE[d] == 0) t = lvl & ~prv;
        else if (P_EDGE[d] == 1) t = ~lvl & prv;
        else t = lvl ^ prv;
        act = (P_EDGE[d] == 1) ? ~lvl : lvl;
        len = int'(pl[c*LW +: LW]);
        if (len == 0) len = 1;
        mf[d][c] = 0;
        if (!en[c]) begin
          md[d][c] = 0; hi[d][c] = 0;
          lk[d][c] = 0; hold[d][c] = 0;
        end else if (lk[d][c] > 0) begin
          lk[d][c]--;
        end else if (hold[d][c]) begin
          if (!act) begin
            md[d][c] = 0; hold[d][c] = 0;
            lk[d][c] = P_LK[d];
          end
        end else if (hi[d][c] > 0) begin
          if (P_RT[d] != 0 && t) begin
            hi[d][c] = len; mf[d][c] = 1;
          end else begin
            hi[d][c]--;
            if (hi[d][c] == 0) begin
              if (P_HD[d] != 0 && act) hold[d][c] = 1;
              else begin
                md[d][c] = 0; lk[d][c] = P_LK[d];
              end
            end
          end
        end else if (t) begin
          md[d][c] = 1; mf[d][c] = 1; hi[d][c] = len;
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = din[c];
    end
  endtask

  task automatic cmp_all(string pfx);
    for (int d = 0; d < ND; d++) begin
      logic [NC-1:0] ed, ef, eb;
      for (int c = 0; c < NC; c++) begin
        ed[c] = md[d][c];
        ef[c] = mf[d][c];
        eb[c] = md[d][c] | (lk[d][c] > 0);
      end
      chk($sformatf("%s.u%0d.dout", pfx, d), o_d[d], ed);
      chk($sformatf("%s.u%0d.fire", pfx, d), o_f[d], ef);
      chk($sformatf("%s.u%0d.busy", pfx, d), o_b[d], eb);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cmp_all("cyc");
  endtask

  initial begin
    int hcnt;
    bit seen;
    rst = 1'b1;
    en  = '1;
    din = '0;
    pl  = {NC{16'd5}};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp_all("reset");

    @(negedge clk);
    rst = 1'b0;
    din[0] = 1'b1;
    repeat (20) cycle();

    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(7) == 0) din[c] = ~din[c];
        en[c] = ($urandom_range(63) != 0);
        if ($urandom_range(3) == 0)
          pl[c*LW +: LW] = LW'($urandom_range(10));
      end
      cycle();
    end

    en  = '1;
    din = '0;
    pl  = {NC{16'd10}};
    repeat (12) cycle();
    din[0] = 1'b1;
    repeat (5) cycle();
    chk("pre_rst.dout", o_d[0][0], 1);
    #3;
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("arst.u%0d.dout", d), o_d[d], 0);
      chk($sformatf("arst.u%0d.busy", d), o_b[d], 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    cmp_all("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) cycle();

    din = '0;
    pl  = {NC{16'd3}};
    pl[LW-1:0] = 16'hFFFF;
    repeat (12) cycle();
    hcnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 66000; k++) begin
      if (k == 1) din[0] = 1'b1;
      if (k == 8) din[0] = 1'b0;
      cycle();
      if (o_d[0][0] === 1'b1) begin
        hcnt++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    chk("len_max", hcnt, 65535);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
